// File: rtl/pipe_pkg.sv
// Shared definitions for the write-back / register-file slice.
package pipe_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef logic [AW_DEF-1:0] reg_num_t;
  typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/pipe_rf_array.sv
// General register storage: one write port, two raw read ports,
// asynchronous clear, entry 0 always reads as zero.
module pipe_rf_array
  import pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra_a_i,
  input  logic [AW-1:0] ra_b_i,
  output logic [DW-1:0] rd_a_o,
  output logic [DW-1:0] rd_b_o
);

  localparam int unsigned NREG = 2 ** AW;

  logic [DW-1:0] mem_q [NREG];

  // Storage update; entry 0 is never written so it stays at its cleared value.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != AW'(REG_ZERO))) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Raw reads with register 0 forced to zero.
  always_comb begin
    rd_a_o = (ra_a_i == AW'(REG_ZERO)) ? '0 : mem_q[ra_a_i];
    rd_b_o = (ra_b_i == AW'(REG_ZERO)) ? '0 : mem_q[ra_b_i];
  end

endmodule

// File: rtl/pipe_wb_regfile.sv
// Write-back stage: result select, register file with write-through
// bypass, registered write-back trace and optional retire counter.
// Optional feature macro: PIPE_WB_RETIRE_CNT_EN (retire_cnt counter).
module pipe_wb_regfile
  import pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          wwreg,
  input  logic          wm2reg,
  input  logic [DW-1:0] wmo,
  input  logic [DW-1:0] walu,
  input  logic [AW-1:0] wrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] wdi,
  output logic          trc_vld,
  output logic [AW-1:0] trc_rn,
  output logic [DW-1:0] trc_data,
  output logic [31:0]   retire_cnt
);

  logic          we;
  logic [DW-1:0] raw_a;
  logic [DW-1:0] raw_b;

  logic          trc_vld_q,  trc_vld_d;
  logic [AW-1:0] trc_rn_q,   trc_rn_d;
  logic [DW-1:0] trc_data_q, trc_data_d;

  // Result select, write qualification and bypassed reads.
  always_comb begin
    wdi = wm2reg ? wmo : walu;
    we  = wwreg && (wrn != AW'(REG_ZERO));
    if (rna == AW'(REG_ZERO))  qa = '0;
    else if (we && wrn == rna) qa = wdi;
    else                       qa = raw_a;
    if (rnb == AW'(REG_ZERO))  qb = '0;
    else if (we && wrn == rnb) qb = wdi;
    else                       qb = raw_b;
  end

  pipe_rf_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk    (clk),
    .clrn   (clrn),
    .we_i   (we),
    .wa_i   (wrn),
    .wd_i   (wdi),
    .ra_a_i (rna),
    .ra_b_i (rnb),
    .rd_a_o (raw_a),
    .rd_b_o (raw_b)
  );

  // Next trace record: the write just performed, or zeros.
  always_comb begin
    trc_vld_d  = we;
    trc_rn_d   = we ? wrn : '0;
    trc_data_d = we ? wdi : '0;
  end

  // Trace registers.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      trc_vld_q  <= 1'b0;
      trc_rn_q   <= '0;
      trc_data_q <= '0;
    end else begin
      trc_vld_q  <= trc_vld_d;
      trc_rn_q   <= trc_rn_d;
      trc_data_q <= trc_data_d;
    end
  end

  assign trc_vld  = trc_vld_q;
  assign trc_rn   = trc_rn_q;
  assign trc_data = trc_data_q;

`ifdef PIPE_WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Retire count advances once per performed write, wrapping naturally.
  always_comb begin
    cnt_d = we ? cnt_q + 32'd1 : cnt_q;
  end

  // Retire counter register.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Scoreboard bench for pipe_wb_regfile: a driver applies stimulus and
// pushes expected outputs from a register-file reference model; a monitor
// pops and compares on the falling clock edge.
module tb_pipe_wb_regfile;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        wwreg = 1'b0;
  logic        wm2reg = 1'b0;
  logic [31:0] wmo = '0;
  logic [31:0] walu = '0;
  logic [4:0]  wrn = '0;
  logic [4:0]  rna = '0;
  logic [4:0]  rnb = '0;
  logic [31:0] qa, qb, wdi, trc_data, retire_cnt;
  logic        trc_vld;
  logic [4:0]  trc_rn;

  pipe_wb_regfile #(
    .DW (32),
    .AW (5)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wmo        (wmo),
    .walu       (walu),
    .wrn        (wrn),
    .rna        (rna),
    .rnb        (rnb),
    .qa         (qa),
    .qb         (qb),
    .wdi        (wdi),
    .trc_vld    (trc_vld),
    .trc_rn     (trc_rn),
    .trc_data   (trc_data),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] wdi;
    logic        vld;
    logic [4:0]  rn;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_rf [32];
  logic        m_vld;
  logic [4:0]  m_rn;
  logic [31:0] m_data;
  logic [31:0] m_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit w,
                                         input logic [4:0] d, input logic [31:0] v);
    if (a == 0)          return 32'h0;
    else if (w && d == a) return v;
    else                 return m_rf[a];
  endfunction

  // One pipeline cycle: retire the previous cycle's write in the model at
  // the rising edge, then apply new inputs and predict the outputs.
  task automatic cycle(input bit r, input bit w, input bit m2, input logic [31:0] mo,
                       input logic [31:0] alu, input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input bit pre);
    logic [31:0] v;
    bit          wr;
    exp_t        e;
    @(posedge clk);
    if (!clrn) begin
      wr = wwreg && (wrn != 0);
      v  = wm2reg ? wmo : walu;
      m_vld  = wr;
      m_rn   = wr ? wrn : 5'd0;
      m_data = wr ? v : 32'h0;
      if (wr) begin
        m_rf[wrn] = v;
        m_cnt     = m_cnt + 1;
      end
    end
    #1;
    clrn = r; wwreg = w; wm2reg = m2; wmo = mo; walu = alu; wrn = d; rna = a; rnb = b;
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_vld = 1'b0; m_rn = '0; m_data = '0; m_cnt = '0;
    end
`ifdef PIPE_WB_RETIRE_CNT_EN
    if (pre) begin
      force dut.cnt_q = 32'hFFFF_FFFE;
      #0 release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
    end
`endif
    v  = m2 ? mo : alu;
    wr = w && (d != 0);
    e.qa   = m_read(a, wr, d, v);
    e.qb   = m_read(b, wr, d, v);
    e.wdi  = v;
    e.vld  = m_vld;
    e.rn   = m_rn;
    e.data = m_data;
`ifdef PIPE_WB_RETIRE_CNT_EN
    e.cnt  = m_cnt;
`else
    e.cnt  = 32'h0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("qa",         qa,                 e.qa);
        chk("qb",         qb,                 e.qb);
        chk("wdi",        wdi,                e.wdi);
        chk("trc_vld",    {31'h0, trc_vld},   {31'h0, e.vld});
        chk("trc_rn",     {27'h0, trc_rn},    {27'h0, e.rn});
        chk("trc_data",   trc_data,           e.data);
        chk("retire_cnt", retire_cnt,         e.cnt);
      end else if (done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    logic [4:0] d;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_vld = 1'b0; m_rn = '0; m_data = '0; m_cnt = '0;

    // Reset
    cycle(1, 0, 0, 0, 0, 0, 1, 2, 0);
    cycle(1, 0, 0, 0, 0, 0, 31, 0, 0);
    // ALU write, then read back with trace
    cycle(0, 1, 0, 32'hDEAD_0000, 32'h1234_5678, 7, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 7, 7, 0);
    // Memory path with same-cycle bypass on both ports, then array read
    cycle(0, 1, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3, 3, 3, 0);
    cycle(0, 0, 0, 0, 0, 0, 3, 7, 0);
    // Zero register write attempt
    cycle(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);
    // No-write with reg5 = 0x11
    cycle(0, 1, 0, 0, 32'h11, 5, 5, 0, 0);
    cycle(0, 0, 0, 0, 32'hAAAA_AAAA, 5, 5, 5, 0);
    cycle(0, 0, 0, 0, 32'hAAAA_AAAA, 5, 5, 5, 0);
    // Counter wrap (preload only takes effect with the counter built in)
    cycle(0, 1, 0, 0, 32'h5555_0001, 9, 9, 1, 1);
    cycle(0, 1, 1, 32'h5555_0002, 0, 10, 9, 10, 0);
    cycle(0, 0, 0, 0, 0, 0, 10, 9, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      d = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom, $urandom, d,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)), 0);
    end

    // Fill registers, assert reset mid-write, then every register reads 0
    for (int i = 1; i < 32; i++)
      cycle(0, 1, 0, 0, $urandom, 5'(i), 5'(i), 5'(32 - i), 0);
    cycle(1, 1, 0, 0, 32'hCAFE_F00D, 12, 12, 4, 0);
    for (int i = 1; i < 32; i++)
      cycle(0, 0, 0, 0, 0, 0, 5'(i), 5'(i), 0);

    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    done = 1'b1;
  end

endmodule

// File: doc/pipe_wb_regfile.md
Name: pipe_wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register; consumes the W-stage control and data signals.
- Selects the result (memory or ALU) and writes it into the 32x32 general register file.
- Serves two combinational read ports to the ID stage, with write-through bypass so a same-cycle write is visible to the reader.
- Also provides a registered write-back trace for the debug/trace logic.

Parameters:
- DW, 32, data width of registers and results.
- AW, 5, register-number width; register count is 2**AW.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- clrn  in  1  reset. Asynchronous, active-high: all state clears on posedge clrn or while high.
- wwreg  in  1  W-stage register-write enable.
- wm2reg  in  1  W-stage result select: 1 selects wmo, 0 selects walu.
- wmo  in  DW  W-stage memory load data.
- walu  in  DW  W-stage ALU result.
- wrn  in  AW  W-stage destination register number.
- rna  in  AW  ID-stage read address A.
- rnb  in  AW  ID-stage read address B.
- qa  out  DW  read data A (combinational).
- qb  out  DW  read data B (combinational).
- wdi  out  DW  selected write-back data (combinational).
- trc_vld  out  1  registered: a register write happened last cycle.
- trc_rn  out  AW  registered destination of that write.
- trc_data  out  DW  registered data of that write.
- retire_cnt  out  32  write-back count; see Optional Feature.

Behaviour:
- wdi = wm2reg ? wmo : walu. Purely combinational.
- Write condition: we = wwreg & (wrn != 0).
- When we is 1, reg[wrn] <= wdi on posedge clk. Register 0 is never stored and always reads 0.
- Read A: rna == 0 gives 0. Else if we & (wrn == rna), qa = wdi (bypass). Else qa = reg[rna].
- Read B uses the same rule with rnb. Both ports may read the same register, including the bypassed one.
- Read latency 0. A write is architecturally visible in the same cycle through the bypass and in later cycles from the array.
- Trace registers update every posedge clk:
  - trc_vld <= we.
  - trc_rn <= we ? wrn : 0.
  - trc_data <= we ? wdi : 0.
- wwreg=1 with wrn=0: no write, no bypass, trc_vld=0.
- Reset (clrn=1), at any time including mid-write:
  - All array entries, trc_vld, trc_rn, trc_data and retire_cnt go to 0 immediately.
  - qa, qb read 0 unless the bypass is active.
  - No write occurs while clrn is high.
- Release of clrn: normal operation resumes from the next posedge clk.
- Inputs are X-free by contract; X on wrn is not protected.

Optional Feature:
- Macro: PIPE_WB_RETIRE_CNT_EN.
- Defined: retire_cnt is a 32-bit register.
  - Increments by 1 on each posedge clk where we=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by clrn.
- Undefined: retire_cnt is tied to 0 and no counter flop is synthesized.

Decomposition:
- Shared package pipe_pkg holds:
  - DW_DEF=32 and AW_DEF=5.
  - REG_ZERO=0.
  - Type reg_num_t (AW-bit vector) and word_t (DW-bit vector).
- One natural sub-module, pipe_rf_array: the storage array with one write port and two raw read ports, async clear, and entry 0 hardwired to 0.
- Top level holds:
  - the wdi mux;
  - the bypass compare;
  - the trace registers;
  - the optional counter.

Test Plan:
- Reset: assert clrn mid-simulation after writes -> qa/qb for rna=rnb=1..31 read 0; trc_vld=0; retire_cnt=0.
- Write/read ALU path: wwreg=1, wm2reg=0, walu=0x1234_5678, wrn=7, one clk -> next cycle rna=7 gives qa=0x12345678; trc_vld=1, trc_rn=7, trc_data=0x12345678.
- Memory path plus bypass: wwreg=1, wm2reg=1, wmo=0xDEAD_BEEF, wrn=3, rna=rnb=3 in the same cycle:
  - before the edge, qa=qb=0xDEADBEEF;
  - after the edge, the array holds 0xDEADBEEF.
- Zero register: wwreg=1, wrn=0, walu=0xFFFF_FFFF -> rna=0 gives qa=0 before and after the edge; trc_vld=0; retire_cnt unchanged.
- No-write: wwreg=0, wrn=5, walu=0xAAAA_AAAA with reg5=0x11 -> qa(rna=5)=0x11 and stays 0x11; trc_vld=0.
- Counter (macro defined): preload path by driving 0xFFFFFFFF writes, or force the counter to 0xFFFFFFFE, then two valid writes -> 0xFFFFFFFF, then 0x00000000.
  - Macro undefined: retire_cnt stays 0 throughout.
